// File: rtl/fifo_reader.sv
// Read-side drain stage: pops a FWFT FIFO into a 2-entry skid buffer feeding a valid/ready stream.
// Optional zero-latency bypass from an empty buffer when FIFO_READER_BYPASS_EN is defined.
module fifo_reader #(
    parameter int C_WIDTH = 32
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               clk_en_i,
    input  logic               flush_i,
    input  logic               fifo_empty_i,
    input  logic [C_WIDTH-1:0] fifo_dout_i,
    output logic               fifo_rd_o,
    output logic               vld_o,
    output logic [C_WIDTH-1:0] data_o,
    input  logic               rdy_i
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [C_WIDTH-1:0] r_buf0;
    logic [C_WIDTH-1:0] r_buf1;
    logic               w_push;
    logic               w_pop;
    logic               w_ld0_in;
    logic               w_ld0_shift;
    logic               w_ld1;

    // The pop strobe looks only at registered occupancy, never at rdy_i.
    assign w_push    = clk_en_i & ~flush_i & ~fifo_empty_i & (r_state != S_TWO) & ~reset_i;
    assign fifo_rd_o = w_push;

`ifdef FIFO_READER_BYPASS_EN
    assign vld_o  = (r_state == S_EMPTY) ? (~fifo_empty_i & ~flush_i & clk_en_i & ~reset_i) : 1'b1;
    assign data_o = ((r_state == S_EMPTY) && !reset_i) ? fifo_dout_i : r_buf0;
`else
    assign vld_o  = (r_state != S_EMPTY);
    assign data_o = r_buf0;
`endif

    assign w_pop = clk_en_i & vld_o & rdy_i & ~flush_i;

    always_comb begin
        w_state_nxt = r_state;
        w_ld0_in    = 1'b0;
        w_ld0_shift = 1'b0;
        w_ld1       = 1'b0;
        if (clk_en_i && flush_i) begin
            w_state_nxt = S_EMPTY;
        end else if (clk_en_i) begin
            case (r_state)
                S_EMPTY: begin
                    // push & pop here is only possible via the bypass path
                    if (w_push && !w_pop) begin
                        w_ld0_in    = 1'b1;
                        w_state_nxt = S_ONE;
                    end
                end
                S_ONE: begin
                    if (w_push && w_pop) begin
                        w_ld0_in = 1'b1;
                    end else if (w_push) begin
                        w_ld1       = 1'b1;
                        w_state_nxt = S_TWO;
                    end else if (w_pop) begin
                        w_state_nxt = S_EMPTY;
                    end
                end
                S_TWO: begin
                    if (w_pop) begin
                        w_ld0_shift = 1'b1;
                        w_state_nxt = S_ONE;
                    end
                end
                default: w_state_nxt = S_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state <= S_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_buf0 <= '0;
            r_buf1 <= '0;
        end else begin
            if (w_ld0_in) begin
                r_buf0 <= fifo_dout_i;
            end else if (w_ld0_shift) begin
                r_buf0 <= r_buf1;
            end
            if (w_ld1) begin
                r_buf1 <= fifo_dout_i;
            end
        end
    end

endmodule

// File: tb/tb_fifo_reader.sv
// Self-checking bench for fifo_reader: FWFT FIFO model feeding the DUT, scoreboard on the output stream.
module tb_fifo_reader;

`ifdef FIFO_READER_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk_i;
    logic        reset_i;
    logic        clk_en_i;
    logic        flush_i;
    logic        fifo_empty_i;
    logic [31:0] fifo_dout_i;
    logic        fifo_rd_o;
    logic        vld_o;
    logic [31:0] data_o;
    logic        rdy_i;

    logic [31:0] fmem [0:63];
    logic [31:0] fwr = '0;
    logic [31:0] frd = '0;
    logic [31:0] exp_q[$];
    int          n_checks = 0;
    int          n_errors = 0;

    fifo_reader #(.C_WIDTH(32)) dut (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .clk_en_i    (clk_en_i),
        .flush_i     (flush_i),
        .fifo_empty_i(fifo_empty_i),
        .fifo_dout_i (fifo_dout_i),
        .fifo_rd_o   (fifo_rd_o),
        .vld_o       (vld_o),
        .data_o      (data_o),
        .rdy_i       (rdy_i)
    );

    assign fifo_empty_i = (fwr == frd);
    assign fifo_dout_i  = fmem[frd[5:0]];

    always @(posedge clk_i) if (fifo_rd_o) frd <= frd + 1;

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, required finish before 100000");
        $fatal(1, "timeout");
    end

    task automatic push_word(input logic [31:0] w);
        fmem[fwr[5:0]] = w;
        fwr = fwr + 1;
        exp_q.push_back(w);
    endtask

    task automatic cycle();
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic test_reset();
        #1;
        n_checks += 2;
        if (vld_o !== 1'b0) begin n_errors++; $display("FAIL por_vld: got %b, required 0", vld_o); end
        if (data_o !== 32'h0) begin n_errors++; $display("FAIL por_data: got %h, required 0", data_o); end
        @(negedge clk_i);
        reset_i = 1'b0;
        rdy_i = 1'b0;
        push_word(32'h5A); push_word(32'h5B); push_word(32'h5C);
        cycle(); cycle();
        #1;
        n_checks += 2;
        if (vld_o !== 1'b1) begin n_errors++; $display("FAIL full_vld: got %b, required 1", vld_o); end
        if (data_o !== 32'h5A) begin n_errors++; $display("FAIL full_data: got %h, required 5a", data_o); end
        #1 reset_i = 1'b1;
        #1;
        n_checks += 3;
        if (vld_o !== 1'b0) begin n_errors++; $display("FAIL rst_vld: got %b, required 0", vld_o); end
        if (data_o !== 32'h0) begin n_errors++; $display("FAIL rst_data: got %h, required 0", data_o); end
        if (fifo_rd_o !== 1'b0) begin n_errors++; $display("FAIL rst_rd: got %b, required 0", fifo_rd_o); end
        @(negedge clk_i);
        reset_i = 1'b0;
        fwr = frd;
        exp_q.delete();
        #1;
        n_checks++;
        if (vld_o !== 1'b0) begin n_errors++; $display("FAIL post_rst_vld: got %b, required 0", vld_o); end
        cycle();
        #1;
        n_checks++;
        if (vld_o !== 1'b0) begin n_errors++; $display("FAIL post_rst_vld2: got %b, required 0", vld_o); end
        @(negedge clk_i);
    endtask

    task automatic test_stream();
        int rd_first, rd_last, rd_cnt, vld_first, x_first, x_last, x_cnt;
        logic [31:0] e;
        rd_first = -1; rd_last = -1; rd_cnt = 0; vld_first = -1;
        x_first = -1; x_last = -1; x_cnt = 0;
        rdy_i = 1'b1;
        push_word(32'h11); push_word(32'h22); push_word(32'h33); push_word(32'h44);
        for (int i = 0; i < 10; i++) begin
            #1;
            if (fifo_rd_o) begin
                if (rd_first < 0) rd_first = i;
                rd_last = i;
                rd_cnt++;
            end
            if (vld_o && vld_first < 0) vld_first = i;
            if (clk_en_i && !flush_i && vld_o && rdy_i) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_errors++; $display("FAIL stream_data: got %h, required no transfer", data_o);
                end else begin
                    e = exp_q.pop_front();
                    if (data_o !== e) begin n_errors++; $display("FAIL stream_data: got %h, required %h", data_o, e); end
                end
                if (x_first < 0) x_first = i;
                x_last = i;
                x_cnt++;
            end
            cycle();
        end
        n_checks += 5;
        if (vld_first - rd_first !== int'(!BYP)) begin
            n_errors++; $display("FAIL stream_latency: got %0d, required %0d", vld_first - rd_first, int'(!BYP));
        end
        if (rd_cnt !== 4 || rd_last - rd_first !== 3) begin
            n_errors++; $display("FAIL stream_rd_run: got %0d pops over %0d cycles, required 4 over 4", rd_cnt, rd_last - rd_first + 1);
        end
        if (x_cnt !== 4) begin n_errors++; $display("FAIL stream_xfers: got %0d, required 4", x_cnt); end
        if (x_last - x_first !== 3) begin
            n_errors++; $display("FAIL stream_consecutive: got span %0d, required 3", x_last - x_first);
        end
        if (exp_q.size() !== 0) begin n_errors++; $display("FAIL stream_left: got %0d pending, required 0", exp_q.size()); end
    endtask

    task automatic test_backpressure();
        int pops, x_cnt;
        logic [31:0] e;
        pops = 0; x_cnt = 0;
        rdy_i = 1'b0;
        for (int k = 0; k < 6; k++) push_word(32'hA0 + k);
        for (int i = 0; i < 5; i++) begin
            #1;
            if (fifo_rd_o) pops++;
            if (vld_o) begin
                n_checks++;
                if (data_o !== 32'hA0) begin n_errors++; $display("FAIL bp_hold: got %h, required a0", data_o); end
            end
            cycle();
        end
        #1;
        n_checks += 2;
        if (pops !== 2) begin n_errors++; $display("FAIL bp_pops: got %0d, required 2", pops); end
        if (vld_o !== 1'b1) begin n_errors++; $display("FAIL bp_vld: got %b, required 1", vld_o); end
        rdy_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (clk_en_i && !flush_i && vld_o && rdy_i) begin
                n_checks++;
                x_cnt++;
                if (exp_q.size() == 0) begin
                    n_errors++; $display("FAIL bp_data: got %h, required no transfer", data_o);
                end else begin
                    e = exp_q.pop_front();
                    if (data_o !== e) begin n_errors++; $display("FAIL bp_data: got %h, required %h", data_o, e); end
                end
            end
            cycle();
        end
        n_checks += 2;
        if (x_cnt !== 6) begin n_errors++; $display("FAIL bp_xfers: got %0d, required 6", x_cnt); end
        if (exp_q.size() !== 0) begin n_errors++; $display("FAIL bp_left: got %0d pending, required 0", exp_q.size()); end
    endtask

    task automatic test_flush();
        int x_cnt;
        logic [31:0] e;
        x_cnt = 0;
        rdy_i = 1'b0;
        push_word(32'h5); push_word(32'h6);
        cycle(); cycle();
        #1;
        n_checks += 2;
        if (vld_o !== 1'b1) begin n_errors++; $display("FAIL fl_pre_vld: got %b, required 1", vld_o); end
        if (data_o !== 32'h5) begin n_errors++; $display("FAIL fl_pre_data: got %h, required 5", data_o); end
        flush_i = 1'b1;
        rdy_i = 1'b1;
        #1;
        n_checks++;
        if (fifo_rd_o !== 1'b0) begin n_errors++; $display("FAIL fl_rd: got %b, required 0", fifo_rd_o); end
        cycle();
        flush_i = 1'b0;
        rdy_i = 1'b0;
        exp_q.delete();
        #1;
        n_checks++;
        if (vld_o !== 1'b0) begin n_errors++; $display("FAIL fl_vld_after: got %b, required 0", vld_o); end
        cycle();
        push_word(32'h7);
        #1;
        n_checks++;
        if (vld_o !== BYP) begin n_errors++; $display("FAIL fl_lat0: got %b, required %b", vld_o, BYP); end
        cycle();
        #1;
        n_checks += 2;
        if (vld_o !== 1'b1) begin n_errors++; $display("FAIL fl_lat1_vld: got %b, required 1", vld_o); end
        if (data_o !== 32'h7) begin n_errors++; $display("FAIL fl_lat1_data: got %h, required 7", data_o); end
        push_word(32'h9);
        flush_i = 1'b1;
        #1;
        n_checks++;
        if (fifo_rd_o !== 1'b0) begin n_errors++; $display("FAIL fl_rd_nonempty: got %b, required 0", fifo_rd_o); end
        cycle();
        flush_i = 1'b0;
        rdy_i = 1'b1;
        exp_q.delete();
        exp_q.push_back(32'h9);
        for (int i = 0; i < 5; i++) begin
            #1;
            if (clk_en_i && !flush_i && vld_o && rdy_i) begin
                n_checks++;
                x_cnt++;
                if (exp_q.size() == 0) begin
                    n_errors++; $display("FAIL fl_data: got %h, required no transfer", data_o);
                end else begin
                    e = exp_q.pop_front();
                    if (data_o !== e) begin n_errors++; $display("FAIL fl_data: got %h, required %h", data_o, e); end
                end
            end
            cycle();
        end
        n_checks++;
        if (x_cnt !== 1) begin n_errors++; $display("FAIL fl_xfers: got %0d, required 1", x_cnt); end
    endtask

    task automatic test_clk_en();
        int x_cnt;
        logic        h_vld;
        logic [31:0] h_data;
        logic [31:0] e;
        x_cnt = 0;
        rdy_i = 1'b1;
        push_word(32'h31); push_word(32'h32); push_word(32'h33);
        for (int i = 0; i < 12; i++) begin
            clk_en_i = !(i >= 1 && i <= 3);
            #1;
            if (i == 1) begin
                h_vld = vld_o;
                h_data = data_o;
            end
            if (!clk_en_i) begin
                n_checks += 3;
                if (fifo_rd_o !== 1'b0) begin n_errors++; $display("FAIL ce_rd: got %b, required 0", fifo_rd_o); end
                if (vld_o !== h_vld) begin n_errors++; $display("FAIL ce_vld_hold: got %b, required %b", vld_o, h_vld); end
                if (data_o !== h_data) begin n_errors++; $display("FAIL ce_data_hold: got %h, required %h", data_o, h_data); end
            end
            if (clk_en_i && !flush_i && vld_o && rdy_i) begin
                n_checks++;
                x_cnt++;
                if (exp_q.size() == 0) begin
                    n_errors++; $display("FAIL ce_data: got %h, required no transfer", data_o);
                end else begin
                    e = exp_q.pop_front();
                    if (data_o !== e) begin n_errors++; $display("FAIL ce_data: got %h, required %h", data_o, e); end
                end
            end
            cycle();
        end
        clk_en_i = 1'b1;
        n_checks++;
        if (x_cnt !== 3) begin n_errors++; $display("FAIL ce_xfers: got %0d, required 3", x_cnt); end
    endtask

    task automatic test_latency();
        int x_cnt;
        logic [31:0] e;
        x_cnt = 0;
        rdy_i = 1'b1;
        push_word(32'hBEEF);
        for (int i = 0; i < 3; i++) begin
            #1;
            if (i == 0) begin
                n_checks += 2;
                if (vld_o !== BYP) begin n_errors++; $display("FAIL lat_vld0: got %b, required %b", vld_o, BYP); end
                if (fifo_rd_o !== 1'b1) begin n_errors++; $display("FAIL lat_rd0: got %b, required 1", fifo_rd_o); end
            end
            if (i == 1) begin
                n_checks++;
                if (vld_o !== !BYP) begin n_errors++; $display("FAIL lat_vld1: got %b, required %b", vld_o, !BYP); end
            end
            if (clk_en_i && !flush_i && vld_o && rdy_i) begin
                n_checks++;
                x_cnt++;
                if (exp_q.size() == 0) begin
                    n_errors++; $display("FAIL lat_data: got %h, required no transfer", data_o);
                end else begin
                    e = exp_q.pop_front();
                    if (data_o !== e) begin n_errors++; $display("FAIL lat_data: got %h, required %h", data_o, e); end
                end
            end
            cycle();
        end
        n_checks++;
        if (x_cnt !== 1) begin n_errors++; $display("FAIL lat_xfers: got %0d, required 1", x_cnt); end
    endtask

    initial begin
        reset_i  = 1'b1;
        clk_en_i = 1'b1;
        flush_i  = 1'b0;
        rdy_i    = 1'b0;
        test_reset();
        test_stream();
        test_backpressure();
        test_flush();
        test_clk_en();
        test_latency();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
